// File: rtl/if_stage_fetchq.sv
// if_stage_fetchq: instruction fetch stage with several fetches in flight.
// Requests go out in order on the inst SRAM-like bus. The PC of each accepted
// request waits in a small queue until its data returns. Returned instructions
// are buffered in an IBUF_DEPTH-entry FIFO in front of ID. A redirect
// (exception, ertn or branch) flushes both queues. Responses still on the bus
// at that point are counted into a discard counter and dropped when they arrive.
// Optional build macro IFQ_BYPASS_EN: when the FIFO is empty and ID is ready,
// a live response goes straight to ID in the same cycle.
module if_stage_fetchq #(
  parameter logic [31:0] RESET_PC   = 32'h1C00_0000,
  parameter int          MAX_OUTSTD = 2,
  parameter int          IBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic        br_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        wb_ex,
  input  logic        wb_ertn,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  output logic        fs_to_ds_valid,
  output logic [64:0] fs_to_ds_bus,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  localparam int CW  = $clog2(MAX_OUTSTD + 1);
  localparam int DW  = CW + 1;
  localparam int FCW = $clog2(IBUF_DEPTH + 1);
  localparam int IPW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
  localparam int QPW = (MAX_OUTSTD > 1) ? $clog2(MAX_OUTSTD) : 1;

  logic [31:0]    r_fetch_pc;
  logic [CW-1:0]  r_outstd;
  logic [DW-1:0]  r_discard;
  logic           r_adef_sent;
  logic [31:0]    r_pcq [MAX_OUTSTD];
  logic [QPW-1:0] r_pq_rp, r_pq_wp;
  logic [64:0]    r_ibuf [IBUF_DEPTH];
  logic [IPW-1:0] r_ib_rp, r_ib_wp;
  logic [FCW-1:0] r_ib_cnt;

  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_aligned, w_ib_full, w_ib_empty;
  logic        w_req, w_hs, w_live, w_drop, w_adef, w_bypass;
  logic        w_ib_push, w_ib_pop;
  logic [31:0] w_pcq_head;
  logic [64:0] w_fwd_data, w_push_data;

  function automatic logic [IPW-1:0] ib_inc(input logic [IPW-1:0] p);
    return (p == IPW'(IBUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [QPW-1:0] pq_inc(input logic [QPW-1:0] p);
    return (p == QPW'(MAX_OUTSTD - 1)) ? '0 : p + 1'b1;
  endfunction

  // Select the redirect source: exception over ertn over a resolved branch.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    w_redirect = 1'b0;
    w_target   = br_target;
    if (wb_ex) begin
      w_redirect = 1'b1;
      w_target   = csr_eentry;
    end else if (wb_ertn) begin
      w_redirect = 1'b1;
      w_target   = csr_era;
    end else if (br_taken && !br_stall) begin
      w_redirect = 1'b1;
      w_target   = br_target;
    end
  end

  assign w_aligned  = (r_fetch_pc[1:0] == 2'b00);
  assign w_ib_full  = (r_ib_cnt == FCW'(IBUF_DEPTH));
  assign w_ib_empty = (r_ib_cnt == '0);
  assign w_pcq_head = r_pcq[r_pq_rp];

  // Each in-flight request must be given a FIFO slot before it is issued, so the FIFO never overflows.
  assign w_req = !reset && !w_redirect && !br_stall && w_aligned &&
                 (int'(r_outstd) < MAX_OUTSTD) &&
                 (int'(r_outstd) + int'(r_ib_cnt) < IBUF_DEPTH);
  assign w_hs   = w_req && inst_sram_addr_ok;
  assign w_live = inst_sram_data_ok && (r_discard == '0);
  assign w_drop = inst_sram_data_ok && (r_discard != '0);

  // A misaligned PC reports one ADEF entry after the bus has drained. Fetch then waits for a redirect.
  assign w_adef = !w_redirect && !w_aligned && (r_outstd == '0) &&
                  (r_discard == '0) && !w_ib_full && !r_adef_sent;

`ifdef IFQ_BYPASS_EN
  assign w_bypass = w_ib_empty && w_live && ds_allowin && !w_redirect;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_fwd_data  = {1'b0, inst_sram_rdata, w_pcq_head};
  assign w_push_data = w_adef ? {1'b1, 32'h0, r_fetch_pc} : w_fwd_data;
  assign w_ib_push   = !w_redirect && ((w_live && !w_bypass) || w_adef);
  assign w_ib_pop    = !w_ib_empty && !w_redirect && ds_allowin;

  assign fs_to_ds_valid = (!w_ib_empty || w_bypass) && !w_redirect;
  assign fs_to_ds_bus   = w_bypass ? w_fwd_data : r_ibuf[r_ib_rp];

  assign inst_sram_req   = w_req;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_addr  = r_fetch_pc;
  assign inst_sram_wdata = 32'h0;

  // Control state: fetch PC, outstanding/discard counters, queue pointers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_fetch_pc  <= RESET_PC;
      r_outstd    <= '0;
      r_discard   <= '0;
      r_adef_sent <= 1'b0;
      r_pq_rp     <= '0;
      r_pq_wp     <= '0;
      r_ib_rp     <= '0;
      r_ib_wp     <= '0;
      r_ib_cnt    <= '0;
    end else if (w_redirect) begin
      r_fetch_pc  <= w_target;
      r_outstd    <= '0;
      r_discard   <= r_discard + {1'b0, r_outstd} - DW'(inst_sram_data_ok);
      r_adef_sent <= 1'b0;
      r_pq_rp     <= '0;
      r_pq_wp     <= '0;
      r_ib_rp     <= '0;
      r_ib_wp     <= '0;
      r_ib_cnt    <= '0;
    end else begin
      if (w_hs) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_pq_wp    <= pq_inc(r_pq_wp);
      end
      if (w_live) r_pq_rp <= pq_inc(r_pq_rp);
      if (w_drop) r_discard <= r_discard - 1'b1;
      if (w_hs && !w_live)      r_outstd <= r_outstd + 1'b1;
      else if (!w_hs && w_live) r_outstd <= r_outstd - 1'b1;
      if (w_ib_push) r_ib_wp <= ib_inc(r_ib_wp);
      if (w_ib_pop)  r_ib_rp <= ib_inc(r_ib_rp);
      if (w_ib_push && !w_ib_pop)      r_ib_cnt <= r_ib_cnt + 1'b1;
      else if (!w_ib_push && w_ib_pop) r_ib_cnt <= r_ib_cnt - 1'b1;
      if (w_adef) r_adef_sent <= 1'b1;
    end
  end

  // Queue storage: written on push, never reset.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays need no reset; pointers and counts decide which entries are valid.
    if (w_hs)      r_pcq[r_pq_wp]  <= r_fetch_pc;
    if (w_ib_push) r_ibuf[r_ib_wp] <= w_push_data;
  end

  // Flag data returned while no request is in flight and none is being discarded.
  always_ff @(posedge clk) begin
    if (!reset) assert (!(inst_sram_data_ok && r_outstd == '0 && r_discard == '0));
  end

endmodule

// File: tb/tb_if_stage_fetchq.sv
// Self-checking bench for if_stage_fetchq: a table of redirect/priority vectors plus
// hand sequences for streaming, outstanding limit, discard, backpressure and ADEF.
// A bus model returns data in order one cycle (or later) after each handshake; the ID
// stream is compared against an expected queue filled by each test.
`timescale 1ns/1ps
module tb_if_stage_fetchq;

  localparam logic [31:0] RPC    = 32'h1C00_0000;
  localparam logic [31:0] EENTRY = 32'h1C00_8000;
  localparam logic [31:0] ERA    = 32'h1C00_4000;
  localparam int          DEPTH  = 4;

  logic        clk, reset;
  logic        ds_allowin, br_stall, br_taken, wb_ex, wb_ertn;
  logic [31:0] br_target, csr_eentry, csr_era;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  if_stage_fetchq #(.RESET_PC(RPC), .MAX_OUTSTD(2), .IBUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .ds_allowin(ds_allowin), .br_stall(br_stall),
    .br_taken(br_taken), .br_target(br_target), .wb_ex(wb_ex), .wb_ertn(wb_ertn),
    .csr_eentry(csr_eentry), .csr_era(csr_era),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] pend[$];
  logic [31:0] hs_log[$];
  logic [64:0] exp_q[$];
  bit          g_addr_ok, g_dok_en, g_allowin;
  bit          g_ex, g_ertn, g_br, g_stall;
  logic [31:0] g_tgt;
  logic        s_req, s_valid;
  logic [31:0] s_addr;
  int          n_id, n_adef;

  typedef struct {
    bit          ex, ertn, br, stall;
    logic [31:0] tgt;
    bit          exp_req;
    logic [31:0] exp_next;
  } vec_t;
  vec_t vecs[7];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA5C3_0F69;
  endfunction

  function automatic logic [64:0] ent(input logic [31:0] pc);
    return {1'b0, mem(pc), pc};
  endfunction

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // One clock: drive at negedge, sample 1ns later, account for what the next posedge commits.
  task automatic cyc();
    @(negedge clk);
    inst_sram_addr_ok = g_addr_ok;
    if (g_dok_en && pend.size() > 0) begin
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = mem(pend[0]);
    end else begin
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = 32'h0;
    end
    ds_allowin = g_allowin;
    wb_ex = g_ex; wb_ertn = g_ertn; br_taken = g_br; br_stall = g_stall; br_target = g_tgt;
    #1;
    s_req = inst_sram_req; s_valid = fs_to_ds_valid; s_addr = inst_sram_addr;
    if (inst_sram_data_ok) void'(pend.pop_front());
    if (inst_sram_req && inst_sram_addr_ok) begin
      pend.push_back(inst_sram_addr);
      hs_log.push_back(inst_sram_addr);
    end
    if (fs_to_ds_valid && ds_allowin) begin
      n_id++;
      if (fs_to_ds_bus[64]) n_adef++;
      if (exp_q.size() > 0) check("id_stream", fs_to_ds_bus, exp_q.pop_front());
    end
  endtask

  task automatic redir(input bit ex, input bit ertn, input bit br, input bit stall,
                       input logic [31:0] tgt);
    g_ex = ex; g_ertn = ertn; g_br = br; g_stall = stall; g_tgt = tgt;
    cyc();
    g_ex = 0; g_ertn = 0; g_br = 0; g_stall = 0; g_tgt = 32'h0;
  endtask

  task automatic drain(input string name, input int bound, output int n);
    n = 0;
    while (exp_q.size() > 0 && n < bound) begin
      cyc();
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic do_reset(input bit chk);
    @(negedge clk);
    reset = 1'b1;
    inst_sram_addr_ok = 0; inst_sram_data_ok = 0; inst_sram_rdata = 0;
    ds_allowin = 0; wb_ex = 0; wb_ertn = 0; br_taken = 0; br_stall = 0; br_target = 0;
    g_addr_ok = 0; g_dok_en = 0; g_allowin = 0;
    g_ex = 0; g_ertn = 0; g_br = 0; g_stall = 0; g_tgt = 0;
    pend.delete(); hs_log.delete(); exp_q.delete();
    n_id = 0; n_adef = 0;
    @(posedge clk); #1;
    if (chk) begin
      check("reset_req", inst_sram_req, 0);
      check("reset_valid", fs_to_ds_valid, 0);
    end
    @(posedge clk); #1;
    if (chk) check("reset_addr", inst_sram_addr, RPC);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected to end by 200000ns");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{1, 0, 0, 0, 32'h1C00_0200, 0, EENTRY};
    vecs[1] = '{1, 1, 1, 0, 32'h1C00_0200, 0, EENTRY};
    vecs[2] = '{0, 1, 1, 0, 32'h1C00_0200, 0, ERA};
    vecs[3] = '{0, 0, 1, 0, 32'h1C00_0200, 0, 32'h1C00_0200};
    vecs[4] = '{0, 0, 1, 1, 32'h1C00_0200, 0, RPC};
    vecs[5] = '{0, 0, 0, 0, 32'h1C00_0200, 1, RPC};
    vecs[6] = '{1, 0, 0, 1, 32'h1C00_0200, 0, EENTRY};

    reset = 1'b1;
    csr_eentry = EENTRY;
    csr_era    = ERA;

    // Reset state and tie-offs
    do_reset(1);
    check("tie_wr", inst_sram_wr, 0);
    check("tie_size", inst_sram_size, 2'b10);
    check("tie_wstrb", inst_sram_wstrb, 0);
    check("tie_wdata", inst_sram_wdata, 0);

    // Redirect priority / issue gating vectors (bus never accepts, so no traffic)
    for (int i = 0; i < 7; i++) begin
      do_reset(0);
      cyc();
      redir(vecs[i].ex, vecs[i].ertn, vecs[i].br, vecs[i].stall, vecs[i].tgt);
      check($sformatf("vec%0d_redir_req", i), s_req, vecs[i].exp_req);
      check($sformatf("vec%0d_redir_valid", i), s_valid, 0);
      cyc();
      check($sformatf("vec%0d_next_addr", i), s_addr, vecs[i].exp_next);
      check($sformatf("vec%0d_next_req", i), s_req, 1);
    end

    // Streaming: sequential PCs, one per cycle once filled
    do_reset(0);
    g_addr_ok = 1; g_dok_en = 1; g_allowin = 1;
    for (int i = 0; i < 12; i++) exp_q.push_back(ent(RPC + 32'(4 * i)));
    drain("stream", 60, n);
    check("stream_throughput", (n <= 14), 1);

    // Outstanding limit: data withheld -> exactly two handshakes
    do_reset(0);
    g_addr_ok = 1; g_allowin = 1;
    repeat (6) cyc();
    check("outstd_hs_count", hs_log.size(), 2);
    check("outstd_hs0", hs_log[0], RPC);
    check("outstd_hs1", hs_log[1], RPC + 32'd4);
    check("outstd_req_low", s_req, 0);
    g_dok_en = 1;
    for (int i = 0; i < 6; i++) exp_q.push_back(ent(RPC + 32'(4 * i)));
    drain("outstd", 60, n);

    // Branch with two in flight: both stale responses dropped
    do_reset(0);
    g_addr_ok = 1; g_allowin = 1;
    repeat (3) cyc();
    check("discard_inflight", hs_log.size(), 2);
    hs_log.delete();
    redir(0, 0, 1, 0, 32'h1C00_0100);
    g_dok_en = 1;
    for (int i = 0; i < 4; i++) exp_q.push_back(ent(32'h1C00_0100 + 32'(4 * i)));
    drain("discard", 60, n);
    check("discard_first_hs", hs_log[0], 32'h1C00_0100);

    // Exception wins over a same-cycle branch while traffic flows
    do_reset(0);
    g_addr_ok = 1; g_dok_en = 1; g_allowin = 1;
    repeat (5) cyc();
    hs_log.delete();
    redir(1, 0, 1, 0, 32'h1C00_0300);
    for (int i = 0; i < 3; i++) exp_q.push_back(ent(EENTRY + 32'(4 * i)));
    drain("ex_prio", 60, n);
    check("ex_prio_first_hs", hs_log[0], EENTRY);

    // Backpressure: FIFO fills to IBUF_DEPTH, nothing lost, order kept
    do_reset(0);
    g_addr_ok = 1; g_dok_en = 1; g_allowin = 0;
    repeat (10) cyc();
    check("bp_hs_count", hs_log.size(), DEPTH);
    check("bp_no_accept", n_id, 0);
    check("bp_valid", s_valid, 1);
    check("bp_req_low", s_req, 0);
    g_allowin = 1;
    for (int i = 0; i < 8; i++) exp_q.push_back(ent(RPC + 32'(4 * i)));
    drain("bp", 60, n);

    // Misaligned branch target: one ADEF entry, no requests, exception restarts
    do_reset(0);
    g_addr_ok = 1; g_dok_en = 1; g_allowin = 1;
    repeat (4) cyc();
    hs_log.delete();
    n_adef = 0;
    redir(0, 0, 1, 0, 32'h1C00_0102);
    exp_q.push_back({1'b1, 32'h0, 32'h1C00_0102});
    drain("adef", 20, n);
    repeat (6) cyc();
    check("adef_no_hs", hs_log.size(), 0);
    check("adef_once", n_adef, 1);
    check("adef_req_low", s_req, 0);
    check("adef_valid_low", s_valid, 0);
    redir(1, 0, 0, 0, 32'h0);
    for (int i = 0; i < 2; i++) exp_q.push_back(ent(EENTRY + 32'(4 * i)));
    drain("adef_restart", 40, n);
    check("adef_restart_hs", hs_log[0], EENTRY);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
